// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES state/byte types and FIPS-197 byte indexing helper
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [7:0]   byte_t;

    localparam int NB = 4;

    // Column-major state layout: matrix element s[r][c] lives in byte r + 4c.
    function automatic int byte_idx(input int r, input int c);
        return r + 4 * c;
    endfunction

endpackage

// File: rtl/inv_shift_rows_core.sv
// rtl/inv_shift_rows_core.sv - combinational (Inv)ShiftRows byte permutation; fwd port under INV_SHIFT_ROWS_FWD_EN
module inv_shift_rows_core
    import aes_pkg::*;
(
    input  state_t state_in,
`ifdef INV_SHIFT_ROWS_FWD_EN
    input  logic   fwd,
`endif
    output state_t state_out
);

    // Each output byte is wired from a fixed source byte; no logic beyond the optional fwd mux.
    for (genvar r = 0; r < NB; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int DST     = byte_idx(r, c);
            localparam int SRC_INV = byte_idx(r, (c + NB - r) % NB);
`ifdef INV_SHIFT_ROWS_FWD_EN
            localparam int SRC_FWD = byte_idx(r, (c + r) % NB);
            assign state_out[127-8*DST -: 8] = fwd ? state_in[127-8*SRC_FWD -: 8]
                                                   : state_in[127-8*SRC_INV -: 8];
`else
            assign state_out[127-8*DST -: 8] = state_in[127-8*SRC_INV -: 8];
`endif
        end
    end

endmodule

// File: rtl/inv_shift_rows.sv
// rtl/inv_shift_rows.sv - registered AES InvShiftRows pipeline slot with valid/ready; INV_SHIFT_ROWS_FWD_EN adds fwd select
module inv_shift_rows
    import aes_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  state_t state_in,
`ifdef INV_SHIFT_ROWS_FWD_EN
    input  logic   fwd,
`endif
    output logic   out_valid,
    input  logic   out_ready,
    output state_t state_out
);

    state_t permuted;
    logic   accept;

    inv_shift_rows_core u_core (
        .state_in  (state_in),
`ifdef INV_SHIFT_ROWS_FWD_EN
        .fwd       (fwd),
`endif
        .state_out (permuted)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A simultaneous consume and accept simply overwrites the slot, keeping out_valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            state_out <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            state_out <= permuted;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inv_shift_rows.sv
// tb/tb_inv_shift_rows.sv - randomized and directed bench for inv_shift_rows (INV_SHIFT_ROWS_FWD_EN optional)
module tb_inv_shift_rows;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         fwd;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inv_shift_rows dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
`ifdef INV_SHIFT_ROWS_FWD_EN
        .fwd       (fwd),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: unpack into a 4x4 matrix and rotate each row one step at a time.
    function automatic logic [127:0] ref_shift(input logic [127:0] s, input logic f);
        logic [7:0]   m [4][4];
        logic [7:0]   t;
        logic [127:0] res;
        for (int k = 0; k < 16; k++) m[k % 4][k / 4] = s[127 - 8*k -: 8];
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < r; n++) begin
                if (f) begin
                    t = m[r][0];
                    m[r][0] = m[r][1]; m[r][1] = m[r][2]; m[r][2] = m[r][3]; m[r][3] = t;
                end else begin
                    t = m[r][3];
                    m[r][3] = m[r][2]; m[r][2] = m[r][1]; m[r][1] = m[r][0]; m[r][0] = t;
                end
            end
        end
        res = '0;
        for (int k = 0; k < 16; k++) res[127 - 8*k -: 8] = m[k % 4][k / 4];
        return res;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [127:0] held;
    logic         exp_valid;
    logic [127:0] exp_data;
    logic         acc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        fwd       = 1'b0;
        state_in  = 128'h00112233445566778899aabbccddeeff;
        tick; tick;
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_state_out", state_out, 128'h0);
        check("reset_in_ready", {127'd0, in_ready}, 128'd1);

        rst_n    = 1'b1;
        state_in = 128'h8923cd6701ab45ef8923cd6701ab45ef;
        tick;
        check("single_valid", {127'd0, out_valid}, 128'd1);
        check("single_data", state_out, 128'h89abcdef0123456789abcdef01234567);
        in_valid = 1'b0;
        tick;
        check("consume_valid", {127'd0, out_valid}, 128'd0);
        check("consume_hold", state_out, 128'h89abcdef0123456789abcdef01234567);

        in_valid = 1'b1;
        state_in = 128'h000102030405060708090a0b0c0d0e0f;
        tick;
        check("b2b_first", state_out, 128'h000d0a0704010e0b0805020f0c090603);
        state_in = 128'h23cd6701ab45ef8923cd6701ab45ef89;
        tick;
        check("b2b_second", state_out, 128'h23456789abcdef0123456789abcdef01);
        check("b2b_valid", {127'd0, out_valid}, 128'd1);
        in_valid = 1'b0;
        tick;

        in_valid  = 1'b1;
        out_ready = 1'b0;
        state_in  = 128'hdeadbeef0123456789abcdeffedcba98;
        tick;
        held     = ref_shift(128'hdeadbeef0123456789abcdeffedcba98, 1'b0);
        state_in = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
            tick;
            check("bp_hold_data", state_out, held);
            check("bp_hold_valid", {127'd0, out_valid}, 128'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {127'd0, in_ready}, 128'd1);
        tick;
        check("bp_swap_data", state_out, ref_shift(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b0));
        check("bp_swap_valid", {127'd0, out_valid}, 128'd1);
        in_valid = 1'b0;
        tick;
        check("bp_drain", {127'd0, out_valid}, 128'd0);

        in_valid  = 1'b1;
        out_ready = 1'b0;
        state_in  = 128'h11111111222222223333333344444444;
        tick;
        check("mid_reset_pre", {127'd0, out_valid}, 128'd1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick;
        check("mid_reset_valid", {127'd0, out_valid}, 128'd0);
        check("mid_reset_data", state_out, 128'h0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick;
        check("mid_reset_gone", {127'd0, out_valid}, 128'd0);

`ifdef INV_SHIFT_ROWS_FWD_EN
        in_valid = 1'b1;
        fwd      = 1'b1;
        state_in = 128'h000102030405060708090a0b0c0d0e0f;
        tick;
        check("fwd_data", state_out, 128'h00050a0f04090e03080d02070c01060b);
        fwd      = 1'b0;
        state_in = state_out;
        tick;
        check("fwd_roundtrip", state_out, 128'h000102030405060708090a0b0c0d0e0f);
        in_valid = 1'b0;
        tick;
`endif

        exp_valid = out_valid === 1'b1;
        exp_data  = state_out;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            state_in  = {$urandom, $urandom, $urandom, $urandom};
`ifdef INV_SHIFT_ROWS_FWD_EN
            fwd = $urandom_range(0, 1) == 1;
`else
            fwd = 1'b0;
`endif
            #1;
            check("rnd_in_ready", {127'd0, in_ready}, {127'd0, !exp_valid || out_ready});
            acc = in_valid && (!exp_valid || out_ready);
            if (acc) begin
                exp_valid = 1'b1;
                exp_data  = ref_shift(state_in, fwd);
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
            tick;
            check("rnd_out_valid", {127'd0, out_valid}, {127'd0, exp_valid});
            if (exp_valid) check("rnd_state_out", state_out, exp_data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
